mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller between the pipeline and the single-port, byte-wide RAM. It arbitrates between the IF-stage instruction fetch and the MEM-stage load/store, with MEM having fixed priority. It sequences multi-byte accesses one byte per cycle, assembles or splits 32-bit words little-endian, and returns the result with a one-cycle completion strobe. It also aborts an in-flight fetch when EX signals a PC jump.

## Interface
- No parameters. RAM address width is fixed at 32 bits and data width at 8 bits.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge
- rst_in  input  1  reset; synchronous, active-high
- pcJump_in  input  1  EX branch/jump taken this cycle; aborts an IF fetch in progress
- IF_MCE_in  input  1  IF fetch request (level, held until served)
- IF_addr_in  input  32  fetch address (PC)
- MEM_MCE_in  input  1  MEM access request (level, held until served)
- MEM_rw_in  input  1  0 = load, 1 = store
- MEM_size_in  input  2  00 byte, 01 half, 10 word; 11 treated as word
- MEM_addr_in  input  32  load/store byte address
- MEM_data_in  input  32  store data; low N bytes used
- ram_din_in  input  8  RAM read data; valid one cycle after address
- MC_busy_out  output  1  high while an access is in flight
- IF_instE_out  output  1  one-cycle strobe: IF_inst_out valid
- IF_inst_out  output  32  fetched instruction
- MEM_done_out  output  1  one-cycle strobe: load data valid / store complete
- MEM_data_out  output  32  load data, zero-extended above N bytes
- ram_addr_out  output  32  RAM byte address
- ram_dout_out  output  8  RAM write data
- ram_wr_out  output  1  1 = write the byte this cycle

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE, arbitration: MEM_MCE_in wins over IF_MCE_in. The winning request's address, size, rw and data are latched into internal registers, and a byte counter k is cleared to 0. IF fetches are always 4 bytes.
- Byte count: N = 1, 2 or 4.
- RD states: drive ram_addr_out = base + k and increment k until k = N−1. Capture ram_din_in one cycle later into byte lane k (lane 0 = bits 7:0, little-endian).
- MEM_WR: per cycle, drive ram_addr_out = base + k, ram_dout_out = MEM_data byte k and ram_wr_out = 1, for k = 0..N−1.
- Address arithmetic: 32-bit modulo add; 0xFFFFFFFF + 1 wraps to 0. Misaligned addresses are legal and need no special handling.
- DONE: exactly one cycle.
  - Asserts IF_instE_out or MEM_done_out, plus the data output.
  - Requests are not sampled in DONE; arbitration resumes in the next cycle in IDLE.
- pcJump_in high during IF_RD: on the next edge go to IDLE, discard the partial instruction, no IF_instE_out.
- pcJump_in during MEM_RD, MEM_WR or DONE: ignored.
- Outputs in IDLE and after reset: every output 0, including ram_addr_out, ram_wr_out, the strobes and the data outputs.
- Data outputs hold 0 outside DONE.
- Reset mid-access: return to IDLE on that edge. A store in progress is truncated (remaining bytes are not written), and no strobe is generated.

## Timing
- Cycle 0 = a cycle in IDLE with a request present; it is sampled at the end of cycle 0.
- Read of N bytes:
  - Addresses are driven in cycles 1..N; byte k is captured at the end of cycle k+2.
  - DONE occurs in cycle N+2. A word read or fetch strobes in cycle 6.
- Write of N bytes: ram_wr_out is high in cycles 1..N; DONE occurs in cycle N+1.
- MC_busy_out: high from cycle 1 through the DONE cycle inclusive, and combinationally low in IDLE.
- Back-to-back accesses: the minimum gap is one IDLE cycle after DONE. The next request's address appears in the cycle after that IDLE cycle.
- A request arriving mid-access waits; requesters hold their request. Starvation of IF while MEM requests continuously is accepted.

## Test plan
- Word fetch: RAM holds bytes 0x13,0x05,0x10,0x00 at 0x100; IF_MCE with addr 0x100 → ram_addr 0x100..0x103 in cycles 1–4, IF_instE_out in cycle 6 with IF_inst_out = 0x00100513, busy high cycles 1–6.
- Simultaneous requests: IF 0x0 and MEM load byte at 0x20 (RAM 0xFF) in the same cycle → MEM served first, MEM_data_out = 0x000000FF in cycle 3. IF is then served, with its address appearing in cycle 5.
- Half store: MEM_rw = 1, size 01, addr 0x40, data 0xDEADBEEF → ram_wr in cycles 1–2 writing 0xEF@0x40 and 0xBE@0x41. MEM_done_out in cycle 3, 0x42/0x43 untouched.
- Jump abort: pcJump_in asserted in cycle 2 of a fetch → IDLE in cycle 3, no IF_instE_out. A new fetch issued after the abort completes normally.
- Wrap-around: word load at 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, with bytes assembled little-endian.
- Reset in cycle 2 of a word store → only bytes 0–1 written, all outputs 0 the next cycle, and the state is IDLE.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: pipeline/RAM-side bus of the byte-serial memory controller.
interface mem_ctrl_if;
    logic        pcJump_in;
    logic        IF_MCE_in;
    logic [31:0] IF_addr_in;
    logic        MEM_MCE_in;
    logic        MEM_rw_in;
    logic [1:0]  MEM_size_in;
    logic [31:0] MEM_addr_in;
    logic [31:0] MEM_data_in;
    logic [7:0]  ram_din_in;
    logic        MC_busy_out;
    logic        IF_instE_out;
    logic [31:0] IF_inst_out;
    logic        MEM_done_out;
    logic [31:0] MEM_data_out;
    logic [31:0] ram_addr_out;
    logic [7:0]  ram_dout_out;
    logic        ram_wr_out;

    modport master (
        output pcJump_in, IF_MCE_in, IF_addr_in, MEM_MCE_in, MEM_rw_in, MEM_size_in,
               MEM_addr_in, MEM_data_in, ram_din_in,
        input  MC_busy_out, IF_instE_out, IF_inst_out, MEM_done_out, MEM_data_out,
               ram_addr_out, ram_dout_out, ram_wr_out
    );

    modport slave (
        input  pcJump_in, IF_MCE_in, IF_addr_in, MEM_MCE_in, MEM_rw_in, MEM_size_in,
               MEM_addr_in, MEM_data_in, ram_din_in,
        output MC_busy_out, IF_instE_out, IF_inst_out, MEM_done_out, MEM_data_out,
               ram_addr_out, ram_dout_out, ram_wr_out
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial IF/MEM arbiter and sequencer for a byte-wide single-port RAM.
module mem_ctrl (
    input logic       clk_in,
    input logic       rst_in,
    mem_ctrl_if.slave mc
);
    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t      state_q;
    logic [31:0] base_q, wdata_q, buf_q;
    logic [2:0]  k_q, n_q;
    logic [31:0] ram_addr_q, inst_q, mdata_q;
    logic [7:0]  ram_dout_q;
    logic        ram_wr_q, inste_q, mdone_q;

    logic [2:0]  kn_d, size_n_d;
    logic [1:0]  lane_d;
    logic [31:0] addr_d, rd_word_d;
    logic [7:0]  wbyte_d;
    logic        last_d;

    // Read data lags its address by a cycle, so the byte arriving now belongs to lane k-1.
    always_comb begin
        kn_d      = k_q + 3'd1;
        lane_d    = k_q[1:0] - 2'd1;
        addr_d    = base_q + {29'd0, kn_d};
        wbyte_d   = wdata_q[{kn_d[1:0], 3'b000} +: 8];
        rd_word_d = buf_q | ({24'd0, mc.ram_din_in} << {lane_d, 3'b000});
        size_n_d  = mc.MEM_size_in == 2'b00 ? 3'd1 : mc.MEM_size_in == 2'b01 ? 3'd2 : 3'd4;
        last_d    = kn_d == n_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            base_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            k_q        <= '0;
            n_q        <= '0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            inst_q     <= '0;
            inste_q    <= 1'b0;
            mdata_q    <= '0;
            mdone_q    <= 1'b0;
        end else begin
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            inst_q     <= '0;
            inste_q    <= 1'b0;
            mdata_q    <= '0;
            mdone_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    k_q   <= '0;
                    buf_q <= '0;
                    if (mc.MEM_MCE_in) begin
                        state_q    <= mc.MEM_rw_in ? MEM_WR : MEM_RD;
                        base_q     <= mc.MEM_addr_in;
                        wdata_q    <= mc.MEM_data_in;
                        n_q        <= size_n_d;
                        ram_addr_q <= mc.MEM_addr_in;
                        ram_dout_q <= mc.MEM_rw_in ? mc.MEM_data_in[7:0] : 8'd0;
                        ram_wr_q   <= mc.MEM_rw_in;
                    end else if (mc.IF_MCE_in) begin
                        state_q    <= IF_RD;
                        base_q     <= mc.IF_addr_in;
                        n_q        <= 3'd4;
                        ram_addr_q <= mc.IF_addr_in;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (k_q != 3'd0)
                        buf_q <= rd_word_d;
                    if (state_q == IF_RD && mc.pcJump_in) begin
                        state_q <= IDLE;
                    end else if (k_q == n_q) begin
                        state_q <= DONE;
                        inste_q <= state_q == IF_RD;
                        mdone_q <= state_q == MEM_RD;
                        inst_q  <= state_q == IF_RD ? rd_word_d : 32'd0;
                        mdata_q <= state_q == MEM_RD ? rd_word_d : 32'd0;
                    end else begin
                        k_q        <= kn_d;
                        ram_addr_q <= last_d ? 32'd0 : addr_d;
                    end
                end
                MEM_WR: begin
                    if (last_d) begin
                        state_q <= DONE;
                        mdone_q <= 1'b1;
                    end else begin
                        k_q        <= kn_d;
                        ram_addr_q <= addr_d;
                        ram_dout_q <= wbyte_d;
                        ram_wr_q   <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mc.MC_busy_out  = state_q != IDLE;
    assign mc.IF_instE_out = inste_q;
    assign mc.IF_inst_out  = inst_q;
    assign mc.MEM_done_out = mdone_q;
    assign mc.MEM_data_out = mdata_q;
    assign mc.ram_addr_out = ram_addr_q;
    assign mc.ram_dout_out = ram_dout_q;
    assign mc.ram_wr_out   = ram_wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven and hand-sequenced checks of mem_ctrl against a byte RAM model.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if mc();
    mem_ctrl dut (.clk_in(clk), .rst_in(rst), .mc(mc));

    typedef struct {
        bit          is_if;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          is_if;
        bit          rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } txn_t;

    exp_t        sb[$];
    exp_t        e;
    txn_t        tbl[10];
    logic [7:0]  mem[logic [31:0]];
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h020: return 8'hFF;
            32'h000: return 8'h01;
            32'h001: return 8'h02;
            32'h002: return 8'h03;
            32'h003: return 8'h04;
            32'h042: return 8'h77;
            32'h043: return 8'h66;
            32'hFFFFFFFE: return 8'hA1;
            32'hFFFFFFFF: return 8'hB2;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_byte(a);
    endfunction

    // RAM model: one-cycle read latency, write on the edge while ram_wr_out is high.
    always @(posedge clk) begin
        mc.ram_din_in <= rd(mc.ram_addr_out);
        if (mc.ram_wr_out)
            mem[mc.ram_addr_out] = mc.ram_dout_out;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one cycle, then score any completion strobe against the queue.
    task automatic tick;
        @(negedge clk);
        if (!mon_en) return;
        if (mc.IF_instE_out || mc.MEM_done_out) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got if=%b mem=%b expected none", mc.IF_instE_out, mc.MEM_done_out);
            end else begin
                e = sb.pop_front();
                if (mc.IF_instE_out !== e.is_if || mc.MEM_done_out !== !e.is_if ||
                    (e.is_if ? mc.IF_inst_out : mc.MEM_data_out) !== e.data ||
                    (e.is_if ? mc.MEM_data_out : mc.IF_inst_out) !== 32'd0) begin
                    failures++;
                    $display("FAIL scoreboard: got if=%b inst=%h mem=%b data=%h expected if=%b data=%h",
                             mc.IF_instE_out, mc.IF_inst_out, mc.MEM_done_out, mc.MEM_data_out, e.is_if, e.data);
                end
            end
        end else begin
            chk("data_hold_zero", mc.IF_inst_out | mc.MEM_data_out, 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_addr"}, mc.ram_addr_out, 32'd0);
        chk({nm, "_ctl"}, {mc.MC_busy_out, mc.IF_instE_out, mc.MEM_done_out, mc.ram_wr_out, mc.ram_dout_out}, 32'd0);
        chk({nm, "_inst"}, mc.IF_inst_out, 32'd0);
        chk({nm, "_mdata"}, mc.MEM_data_out, 32'd0);
    endtask

    task automatic run_txn(input txn_t t);
        int  lat;
        bit  seen;
        lat = t.is_if ? 6 : ((t.size == 2'b00 ? 1 : t.size == 2'b01 ? 2 : 4) + (t.rw ? 1 : 2));
        tick();
        if (t.is_if) begin
            mc.IF_MCE_in  = 1'b1;
            mc.IF_addr_in = t.addr;
        end else begin
            mc.MEM_MCE_in  = 1'b1;
            mc.MEM_rw_in   = t.rw;
            mc.MEM_size_in = t.size;
            mc.MEM_addr_in = t.addr;
            mc.MEM_data_in = t.wdata;
        end
        sb.push_back('{t.is_if, t.exp});
        seen = 1'b0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            tick();
            if (c == 1) begin
                mc.IF_MCE_in  = 1'b0;
                mc.MEM_MCE_in = 1'b0;
            end
            if (mc.IF_instE_out || mc.MEM_done_out) begin
                seen = 1'b1;
                chk("latency", c, lat);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout: got no strobe expected one within 12 cycles (addr %h)", t.addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mc.pcJump_in   = 1'b0;
        mc.IF_MCE_in   = 1'b0;
        mc.IF_addr_in  = '0;
        mc.MEM_MCE_in  = 1'b0;
        mc.MEM_rw_in   = 1'b0;
        mc.MEM_size_in = '0;
        mc.MEM_addr_in = '0;
        mc.MEM_data_in = '0;
        tbl[0] = '{0, 1, 2'b10, 32'h200, 32'h11223344, 32'h0};
        tbl[1] = '{0, 0, 2'b10, 32'h200, 32'h0, 32'h11223344};
        tbl[2] = '{0, 0, 2'b01, 32'h202, 32'h0, 32'h00001122};
        tbl[3] = '{0, 0, 2'b00, 32'h203, 32'h0, 32'h00000011};
        tbl[4] = '{0, 1, 2'b00, 32'h201, 32'hFFFFFF99, 32'h0};
        tbl[5] = '{0, 0, 2'b10, 32'h200, 32'h0, 32'h11229944};
        tbl[6] = '{0, 1, 2'b01, 32'h203, 32'hAAAABBCC, 32'h0};
        tbl[7] = '{0, 0, 2'b10, 32'h201, 32'h0, 32'hBBCC2299};
        tbl[8] = '{1, 0, 2'b10, 32'h200, 32'h0, 32'hCC229944};
        tbl[9] = '{0, 0, 2'b11, 32'h200, 32'h0, 32'hCC229944};

        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Word fetch at 0x100
        tick();
        mc.IF_MCE_in  = 1'b1;
        mc.IF_addr_in = 32'h100;
        sb.push_back('{1'b1, 32'h00100513});
        chk("fetch_c0_busy", mc.MC_busy_out, 0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) mc.IF_MCE_in = 1'b0;
            chk("fetch_busy", mc.MC_busy_out, c <= 6);
            if (c <= 4) chk("fetch_addr", mc.ram_addr_out, 32'h100 + c - 1);
            chk("fetch_strobe", mc.IF_instE_out, c == 6);
        end

        // Simultaneous IF and MEM: MEM first, IF address in cycle 5
        tick();
        mc.IF_MCE_in   = 1'b1;
        mc.IF_addr_in  = 32'h0;
        mc.MEM_MCE_in  = 1'b1;
        mc.MEM_rw_in   = 1'b0;
        mc.MEM_size_in = 2'b00;
        mc.MEM_addr_in = 32'h20;
        sb.push_back('{1'b0, 32'h000000FF});
        sb.push_back('{1'b1, 32'h04030201});
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
                mc.MEM_MCE_in = 1'b0;
                chk("arb_mem_addr", mc.ram_addr_out, 32'h20);
            end
            if (c == 3) chk("arb_mem_done", mc.MEM_done_out, 1);
            if (c == 4) chk("arb_gap_idle", mc.MC_busy_out, 0);
            if (c == 5) begin
                chk("arb_if_busy", mc.MC_busy_out, 1);
                chk("arb_if_addr0", mc.ram_addr_out, 32'h0);
                mc.IF_MCE_in = 1'b0;
            end
            if (c == 6) chk("arb_if_addr1", mc.ram_addr_out, 32'h1);
            if (c == 10) chk("arb_if_strobe", mc.IF_instE_out, 1);
        end

        // Half store at 0x40
        tick();
        mc.MEM_MCE_in  = 1'b1;
        mc.MEM_rw_in   = 1'b1;
        mc.MEM_size_in = 2'b01;
        mc.MEM_addr_in = 32'h40;
        mc.MEM_data_in = 32'hDEADBEEF;
        sb.push_back('{1'b0, 32'h0});
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) mc.MEM_MCE_in = 1'b0;
            chk("hs_wr", mc.ram_wr_out, c <= 2);
            if (c <= 2) begin
                chk("hs_addr", mc.ram_addr_out, 32'h40 + c - 1);
                chk("hs_dout", mc.ram_dout_out, c == 1 ? 32'hEF : 32'hBE);
            end
            if (c == 3) chk("hs_done", mc.MEM_done_out, 1);
        end
        chk("hs_mem40", rd(32'h40), 32'hEF);
        chk("hs_mem41", rd(32'h41), 32'hBE);
        chk("hs_mem42", rd(32'h42), 32'h77);
        chk("hs_mem43", rd(32'h43), 32'h66);

        // Jump abort in cycle 2 of a fetch, then a clean refetch
        tick();
        mc.IF_MCE_in  = 1'b1;
        mc.IF_addr_in = 32'h100;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) mc.IF_MCE_in = 1'b0;
            if (c == 2) mc.pcJump_in = 1'b1;
            if (c == 3) mc.pcJump_in = 1'b0;
            if (c >= 3) chk("jump_idle", mc.MC_busy_out, 0);
            chk("jump_nostrobe", mc.IF_instE_out, 0);
        end
        run_txn('{1, 0, 2'b10, 32'h100, 32'h0, 32'h00100513});

        // Word load wrapping past 0xFFFFFFFF
        tick();
        mc.MEM_MCE_in  = 1'b1;
        mc.MEM_rw_in   = 1'b0;
        mc.MEM_size_in = 2'b10;
        mc.MEM_addr_in = 32'hFFFFFFFE;
        sb.push_back('{1'b0, 32'h0201B2A1});
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) mc.MEM_MCE_in = 1'b0;
            if (c <= 4) chk("wrap_addr", mc.ram_addr_out, 32'hFFFFFFFE + 32'(c - 1));
            if (c == 6) chk("wrap_done", mc.MEM_done_out, 1);
        end

        // Reset in cycle 2 of a word store
        tick();
        mc.MEM_MCE_in  = 1'b1;
        mc.MEM_rw_in   = 1'b1;
        mc.MEM_size_in = 2'b10;
        mc.MEM_addr_in = 32'h300;
        mc.MEM_data_in = 32'h44332211;
        tick();
        mc.MEM_MCE_in = 1'b0;
        chk("rst_wr_c1", mc.ram_wr_out, 1);
        tick();
        chk("rst_addr_c2", mc.ram_addr_out, 32'h301);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_mid");
        tick();
        chk("rst_idle", mc.MC_busy_out, 0);
        chk("rst_mem300", rd(32'h300), 32'h11);
        chk("rst_mem301", rd(32'h301), 32'h22);
        chk("rst_mem302", rd(32'h302), 32'h00);
        chk("rst_mem303", rd(32'h303), 32'h00);

        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
